// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: defaults, FSM encoding, counter width.
package mem_ctrl_pkg;

    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned SRAM_AW_DEF     = 18;
    localparam int unsigned CNT_W           = 3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLo   = 2'd1;
    localparam state_t StHi   = 2'd2;
    localparam state_t StDone = 2'd3;

endpackage

// File: rtl/sram_phase_cnt.sv
// Phase timer for one SRAM halfword phase; tc marks the last cycle of the phase.
module sram_phase_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MAX = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit access as two 16-bit SRAM phases, stalling the pipeline meanwhile.
module mem_stage_sram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_t             state_q, state_d;
    logic [SRAM_AW-2:0] addr_q;
    logic [31:0]        wr_data_q;
    logic               op_wr_q;
    logic [31:0]        rd_data_q;
    logic               in_phase;
    logic               tc;
    logic               req;
    logic               unused_addr;

    assign unused_addr = ^{addr[31:SRAM_AW+1], addr[1:0]};
    assign req         = mem_r_en | mem_w_en;
    assign in_phase    = (state_q == StLo) || (state_q == StHi);

    // Counter restarts on every phase boundary so LO and HI time out independently.
    sram_phase_cnt #(
        .MAX (WAIT_CYCLES)
    ) u_phase_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_phase || tc),
        .en  (in_phase),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req) state_d = StLo;
            StLo:    if (tc) state_d = StHi;
            StHi:    if (tc) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wr_data_q <= '0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                addr_q    <= addr[SRAM_AW:2];
                wr_data_q <= wr_data;
                op_wr_q   <= mem_w_en;
            end
            if (tc && !op_wr_q && state_q == StLo) rd_data_q[15:0]  <= sram_dq_in;
            if (tc && !op_wr_q && state_q == StHi) rd_data_q[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            StIdle:  ready = !req;
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign freeze      = ~ready;
    assign rd_data     = rd_data_q;
    assign sram_addr   = {addr_q, (state_q == StHi)};
    assign sram_dq_out = (state_q == StHi) ? wr_data_q[31:16] : wr_data_q[15:0];
    assign sram_dq_oe  = in_phase && op_wr_q;
    assign sram_ce_n   = !in_phase;
    assign sram_oe_n   = !(in_phase && !op_wr_q);
    // Write strobe released on the final phase cycle to give the SRAM data hold time.
    assign sram_we_n   = !(in_phase && op_wr_q && !tc);

endmodule
